// File: rtl/uart_frame_pkg.sv
// Shared types and sizes for the UART frame receive/transmit path.
package uart_frame_pkg;

   localparam int BYTE_W              = 8;
   // Work-block size; the TX framer uses the same default
   localparam int DEFAULT_FRAME_BYTES = 80;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_HOLD = 2'd2
   } frame_state_e;

endpackage

// File: rtl/uart_frame_rx_timeout.sv
// Idle-gap counter: counts enabled cycles since the last clear and pulses
// expire_o on the cycle the count reaches TIMEOUT_CYCLES.
module frame_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic unused_ok;
         assign unused_ok = ^{clk, rst, en_i, clr_i};
         assign expire_o  = 1'b0;
      end else begin : g_counter
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
               cnt_d = '0;
            end else if (en_i) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         // Fires while the count steps from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES
         assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles FRAME_BYTES UART bytes into one work block and offers it to the
// nonce controller over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | no frame in progress, waiting for byte 0
//   RECV  | collecting bytes 1..FRAME_BYTES-1, idle timer armed
//   HOLD  | full frame presented, waiting for frame_ready
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int          FRAME_BYTES    = DEFAULT_FRAME_BYTES,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          MSB_FIRST      = 1'b0,
   parameter int          CNT_W          = $clog2(FRAME_BYTES + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_valid_i,
   input  logic [BYTE_W-1:0]             rx_data_i,
   input  logic                          frame_ready_i,
   output logic                          frame_valid_o,
   output logic [BYTE_W*FRAME_BYTES-1:0] frame_data_o,
   output logic                          busy_o,
   output logic [CNT_W-1:0]              byte_count_o,
   output logic                          timeout_err_o,
   output logic                          overrun_err_o
);

   frame_state_e                    state_q, state_d;
   logic [CNT_W-1:0]                count_q, count_d;
   logic [BYTE_W*FRAME_BYTES-1:0]   data_q, data_d;
   logic                            tmo_err_q, tmo_err_d;
   logic                            ovr_err_q, ovr_err_d;
   logic                            wr_en;
   logic [CNT_W-1:0]                wr_k;
   logic                            expire;

   function automatic int lane_idx(input logic [CNT_W-1:0] k);
      return MSB_FIRST ? (FRAME_BYTES - 1 - int'(k)) : int'(k);
   endfunction

   frame_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .en_i     (state_q == ST_RECV),
      .clr_i    (rx_valid_i || (state_q != ST_RECV)),
      .expire_o (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         data_q    <= '0;
         tmo_err_q <= 1'b0;
         ovr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         data_q    <= data_d;
         tmo_err_q <= tmo_err_d;
         ovr_err_q <= ovr_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      data_d    = data_q;
      tmo_err_d = 1'b0;
      ovr_err_d = 1'b0;
      wr_en     = 1'b0;
      wr_k      = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid_i) begin
               wr_en   = 1'b1;
               count_d = CNT_W'(1);
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (rx_valid_i) begin
               wr_en   = 1'b1;
               wr_k    = count_q;
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(FRAME_BYTES - 1)) begin
                  state_d = ST_HOLD;
               end
            end else if (expire) begin
               tmo_err_d = 1'b1;
               count_d   = '0;
               state_d   = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (frame_ready_i) begin
               // A byte arriving with the handshake opens the next frame
               if (rx_valid_i) begin
                  wr_en   = 1'b1;
                  count_d = CNT_W'(1);
                  state_d = ST_RECV;
               end else begin
                  count_d = '0;
                  state_d = ST_IDLE;
               end
            end else if (rx_valid_i) begin
               ovr_err_d = 1'b1;
            end
         end
         default: begin
            count_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (wr_en) begin
         data_d[BYTE_W*lane_idx(wr_k) +: BYTE_W] = rx_data_i;
      end
   end

   always_comb begin
      frame_valid_o = (state_q == ST_HOLD);
      busy_o        = (state_q == ST_RECV);
   end

   assign frame_data_o  = data_q;
   assign byte_count_o  = count_q;
   assign timeout_err_o = tmo_err_q;
   assign overrun_err_o = ovr_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three configurations on shared stimulus, expected
// frames queued when bytes are driven and compared when frame_valid rises.
module tb_uart_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       frame_ready = 1'b0;

   logic         fv_a, busy_a, tmo_a, ovr_a;
   logic [2:0]   cnt_a;
   logic [31:0]  data_a;
   logic         fv_b, busy_b, tmo_b, ovr_b;
   logic [2:0]   cnt_b;
   logic [31:0]  data_b;
   logic         fv_c, busy_c, tmo_c, ovr_c;
   logic [6:0]   cnt_c;
   logic [639:0] data_c;

   int n_tests = 0;
   int n_fail  = 0;
   logic [639:0] exp_q[$];

   always #5 clk = ~clk;

   uart_frame_rx #(.FRAME_BYTES(4), .TIMEOUT_CYCLES(0), .MSB_FIRST(1'b0)) u_a (
      .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .frame_ready_i(frame_ready), .frame_valid_o(fv_a), .frame_data_o(data_a),
      .busy_o(busy_a), .byte_count_o(cnt_a), .timeout_err_o(tmo_a), .overrun_err_o(ovr_a));

   uart_frame_rx #(.FRAME_BYTES(4), .TIMEOUT_CYCLES(100), .MSB_FIRST(1'b1)) u_b (
      .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .frame_ready_i(frame_ready), .frame_valid_o(fv_b), .frame_data_o(data_b),
      .busy_o(busy_b), .byte_count_o(cnt_b), .timeout_err_o(tmo_b), .overrun_err_o(ovr_b));

   uart_frame_rx #(.FRAME_BYTES(80), .TIMEOUT_CYCLES(50), .MSB_FIRST(1'b0)) u_c (
      .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .frame_ready_i(frame_ready), .frame_valid_o(fv_c), .frame_data_o(data_c),
      .busy_o(busy_c), .byte_count_o(cnt_c), .timeout_err_o(tmo_c), .overrun_err_o(ovr_c));

   function automatic logic [639:0] place(input logic [639:0] f, input int fb,
                                          input bit msb, input int k, input logic [7:0] b);
      int idx;
      idx = msb ? (fb - 1 - k) : k;
      f[idx*8 +: 8] = b;
      return f;
   endfunction

   function automatic logic get_fv(input int s);
      case (s)
         0:       return fv_a;
         1:       return fv_b;
         default: return fv_c;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic rdy);
      @(negedge clk);
      rx_valid    = 1'b1;
      rx_data     = b;
      frame_ready = rdy;
      @(negedge clk);
      rx_valid    = 1'b0;
      frame_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
   endtask

   task automatic wait_valid(input int s, output bit ok);
      int k = 0;
      while (!get_fv(s) && k < 300) begin
         @(negedge clk);
         k++;
      end
      ok = get_fv(s);
   endtask

   task automatic test_reset();
      idle(2);
      n_tests++;
      if ({fv_a, busy_a, tmo_a, ovr_a, cnt_a} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl_a: got %b want 0", {fv_a, busy_a, tmo_a, ovr_a, cnt_a});
      end
      n_tests++;
      if (data_a !== 32'd0 || data_c !== 640'd0) begin
         n_fail++;
         $display("FAIL reset_data: got a=%h want 0", data_a);
      end
      n_tests++;
      if ({fv_c, busy_c, tmo_c, ovr_c, cnt_c} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl_c: got %b want 0", {fv_c, busy_c, tmo_c, ovr_c, cnt_c});
      end
      rst = 1'b0;
   endtask

   task automatic test_lsb_frame();
      logic [639:0] exp, got;
      logic [7:0]   b;
      do_reset();
      exp = '0;
      for (int i = 0; i < 4; i++) begin
         b   = 8'(8'h11 * (i + 1));
         exp = place(exp, 4, 1'b0, i, b);
         if (i == 3) exp_q.push_back(exp);
         n_tests++;
         if (fv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_early_valid byte %0d: got %b want 0", i, fv_a);
         end
         send_byte(b, 1'b0);
         n_tests++;
         if (busy_a !== (i < 3) || cnt_a !== 3'(i + 1)) begin
            n_fail++;
            $display("FAIL lsb_busy_cnt byte %0d: got busy=%b cnt=%0d want busy=%b cnt=%0d",
                     i, busy_a, cnt_a, (i < 3), i + 1);
         end
         if (i < 3) idle(3);
      end
      n_tests++;
      if (fv_a !== 1'b1) begin
         n_fail++;
         $display("FAIL lsb_latency: frame_valid got %b want 1", fv_a);
      end
      got = {608'd0, data_a};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp || data_a !== 32'h44332211) begin
         n_fail++;
         $display("FAIL lsb_data: got %h want %h", data_a, exp[31:0]);
      end
      pulse_ready();
      n_tests++;
      if (fv_a !== 1'b0 || cnt_a !== 3'd0) begin
         n_fail++;
         $display("FAIL lsb_release: got fv=%b cnt=%0d want 0 0", fv_a, cnt_a);
      end
   endtask

   task automatic test_msb_hold();
      logic [639:0] exp;
      logic [7:0]   b;
      bit           ok;
      do_reset();
      exp = '0;
      for (int i = 0; i < 4; i++) begin
         b   = 8'(8'h11 * (i + 1));
         exp = place(exp, 4, 1'b1, i, b);
         send_byte(b, 1'b0);
         if (i < 3) idle(3);
      end
      exp_q.push_back(exp);
      wait_valid(1, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL msb_valid: frame_valid got 0 want 1");
      end
      exp = exp_q.pop_front();
      n_tests++;
      if (data_b !== exp[31:0] || data_b !== 32'h11223344) begin
         n_fail++;
         $display("FAIL msb_data: got %h want %h", data_b, exp[31:0]);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (fv_b !== 1'b1 || data_b !== exp[31:0]) begin
            n_fail++;
            $display("FAIL msb_hold cycle %0d: got fv=%b data=%h want 1 %h", c, fv_b, data_b, exp[31:0]);
         end
      end
      pulse_ready();
      n_tests++;
      if (fv_b !== 1'b0 || cnt_b !== 3'd0 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL msb_release: got fv=%b cnt=%0d busy=%b want 0 0 0", fv_b, cnt_b, busy_b);
      end
   endtask

   task automatic test_overrun();
      logic [639:0] exp;
      logic [7:0]   b;
      bit           ok;
      do_reset();
      exp = '0;
      for (int i = 0; i < 4; i++) begin
         b   = 8'(8'hA1 + i);
         exp = place(exp, 4, 1'b0, i, b);
         send_byte(b, 1'b0);
      end
      exp_q.push_back(exp);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hAA; frame_ready = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      n_tests++;
      if (ovr_a !== 1'b1 || fv_a !== 1'b1 || cnt_a !== 3'd4 || data_a !== exp[31:0]) begin
         n_fail++;
         $display("FAIL overrun: got ovr=%b fv=%b cnt=%0d data=%h want 1 1 4 %h",
                  ovr_a, fv_a, cnt_a, data_a, exp[31:0]);
      end
      rx_valid = 1'b1; rx_data = 8'h55; frame_ready = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; frame_ready = 1'b0;
      exp = place(exp, 4, 1'b0, 0, 8'h55);
      n_tests++;
      if (ovr_a !== 1'b0 || fv_a !== 1'b0 || cnt_a !== 3'd1 || busy_a !== 1'b1 || data_a !== exp[31:0]) begin
         n_fail++;
         $display("FAIL b2b_handshake: got ovr=%b fv=%b cnt=%0d busy=%b data=%h want 0 0 1 1 %h",
                  ovr_a, fv_a, cnt_a, busy_a, data_a, exp[31:0]);
      end
      for (int i = 1; i < 4; i++) begin
         b   = 8'(8'h55 + 8'h11 * i);
         exp = place(exp, 4, 1'b0, i, b);
         send_byte(b, 1'b0);
      end
      exp_q.push_back(exp);
      wait_valid(0, ok);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || data_a !== exp[31:0]) begin
         n_fail++;
         $display("FAIL b2b_frame: got fv=%b data=%h want 1 %h", ok, data_a, exp[31:0]);
      end
      pulse_ready();
   endtask

   task automatic test_reset_mid();
      logic [639:0] exp;
      bit           ok;
      do_reset();
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if ({fv_a, busy_a, tmo_a, ovr_a, cnt_a} !== 7'd0 || data_a !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got ctrl=%b data=%h want 0 0",
                  {fv_a, busy_a, tmo_a, ovr_a, cnt_a}, data_a);
      end
      @(negedge clk);
      rst = 1'b0;
      exp = '0;
      for (int i = 0; i < 4; i++) begin
         exp = place(exp, 4, 1'b0, i, 8'(i + 1));
         send_byte(8'(i + 1), 1'b0);
      end
      exp_q.push_back(exp);
      wait_valid(0, ok);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || data_a !== exp[31:0] || data_a !== 32'h04030201) begin
         n_fail++;
         $display("FAIL reset_mid_frame: got fv=%b data=%h want 1 %h", ok, data_a, exp[31:0]);
      end
      pulse_ready();
   endtask

   task automatic test_timeout();
      logic [639:0] exp;
      logic [7:0]   b;
      int           pulses, at;
      bit           ok;
      do_reset();
      exp = '0;
      for (int i = 0; i < 10; i++) begin
         b   = 8'($urandom_range(255));
         exp = place(exp, 80, 1'b0, i, b);
         send_byte(b, 1'b0);
      end
      pulses = 0;
      at     = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (tmo_c) begin
            pulses++;
            at = c;
         end
         if (c == 45) begin
            n_tests++;
            if (busy_c !== 1'b1 || cnt_c !== 7'd10) begin
               n_fail++;
               $display("FAIL timeout_early: got busy=%b cnt=%0d want 1 10", busy_c, cnt_c);
            end
         end
      end
      n_tests++;
      if (pulses != 1 || at != 50) begin
         n_fail++;
         $display("FAIL timeout_pulse: got %0d pulses at cycle %0d want 1 at 50", pulses, at);
      end
      n_tests++;
      if (cnt_c !== 7'd0 || busy_c !== 1'b0 || fv_c !== 1'b0 || data_c !== exp) begin
         n_fail++;
         $display("FAIL timeout_state: got cnt=%0d busy=%b fv=%b want 0 0 0, data kept", cnt_c, busy_c, fv_c);
      end
      for (int i = 0; i < 80; i++) begin
         b   = 8'($urandom_range(255));
         exp = place(exp, 80, 1'b0, i, b);
         send_byte(b, 1'b0);
      end
      exp_q.push_back(exp);
      wait_valid(2, ok);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || data_c !== exp || cnt_c !== 7'd80) begin
         n_fail++;
         $display("FAIL timeout_full_frame: got fv=%b cnt=%0d data_lo=%h want 1 80 %h",
                  ok, cnt_c, data_c[63:0], exp[63:0]);
      end
      pulse_ready();
   endtask

   task automatic test_no_timeout();
      logic [639:0] exp;
      int           pulses;
      bit           ok;
      do_reset();
      exp = '0;
      for (int i = 0; i < 2; i++) begin
         exp = place(exp, 4, 1'b0, i, 8'(8'hC0 + i));
         send_byte(8'(8'hC0 + i), 1'b0);
      end
      pulses = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (tmo_a) pulses++;
      end
      n_tests++;
      if (pulses != 0 || busy_a !== 1'b1 || cnt_a !== 3'd2) begin
         n_fail++;
         $display("FAIL no_timeout: got pulses=%0d busy=%b cnt=%0d want 0 1 2", pulses, busy_a, cnt_a);
      end
      for (int i = 2; i < 4; i++) begin
         exp = place(exp, 4, 1'b0, i, 8'(8'hC0 + i));
         send_byte(8'(8'hC0 + i), 1'b0);
      end
      exp_q.push_back(exp);
      wait_valid(0, ok);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || data_a !== exp[31:0]) begin
         n_fail++;
         $display("FAIL no_timeout_frame: got fv=%b data=%h want 1 %h", ok, data_a, exp[31:0]);
      end
      pulse_ready();
   endtask

   initial begin
      test_reset();
      test_lsb_frame();
      test_msb_hold();
      test_overrun();
      test_reset_mid();
      test_timeout();
      test_no_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
